// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline latch plus architectural NZCV flag register.
// Live ALU flags bypass into the B.cond evaluator in the same cycle.
module ex_mem_stage #(
  parameter int DATA_W = 64,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              ex_negative,
  input  logic              ex_zero,
  input  logic              ex_overflow,
  input  logic              ex_carry_out,
  input  logic              ex_valid,
  input  logic              ex_setflags,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic              ex_memwrite,
  input  logic              ex_memtoreg,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic              stall,
  input  logic              flush,
  input  logic [3:0]        cond_code,
  output logic [DATA_W-1:0] mem_result,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [REG_W-1:0]  mem_rd,
  output logic              mem_valid,
  output logic              mem_regwrite,
  output logic              mem_memread,
  output logic              mem_memwrite,
  output logic              mem_memtoreg,
  output logic [3:0]        flags,
  output logic              cond_true
);

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] store_data;
    logic [REG_W-1:0]  rd;
    logic              valid;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
    logic              memtoreg;
  } ex_mem_t;

  ex_mem_t    r_lat;
  ex_mem_t    w_next;
  logic [3:0] r_flags;
  logic [3:0] w_ex_flags;
  logic [3:0] w_eff;
  logic       w_bypass;
  logic       w_set;
  logic       w_base;
  logic       w_n;
  logic       w_z;
  logic       w_c;
  logic       w_v;

  // Controls of a bubble must never reach MEM/WB; data is harmless.
  always_comb begin
    w_next            = '0;
    w_next.result     = ex_result;
    w_next.store_data = ex_store_data;
    w_next.rd         = ex_rd;
    w_next.valid      = ex_valid;
    w_next.regwrite   = ex_regwrite & ex_valid;
    w_next.memread    = ex_memread  & ex_valid;
    w_next.memwrite   = ex_memwrite & ex_valid;
    w_next.memtoreg   = ex_memtoreg & ex_valid;
  end

  assign w_ex_flags = {ex_negative, ex_zero,
                       ex_carry_out, ex_overflow};
  assign w_set      = ex_valid & ex_setflags;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lat   <= '0;
      r_flags <= 4'b0000;
    end else if (flush) begin
      r_lat   <= '0;
    end else if (!stall) begin
      r_lat <= w_next;
      if (w_set)
        r_flags <= w_ex_flags;
    end
  end

  // Stall does not gate the bypass: B.cond sees the ADDS/SUBS result now.
  assign w_bypass = w_set & ~flush & ~reset;
  assign w_eff    = w_bypass ? w_ex_flags : r_flags;
  assign w_n      = w_eff[3];
  assign w_z      = w_eff[2];
  assign w_c      = w_eff[1];
  assign w_v      = w_eff[0];

  always_comb begin
    w_base = 1'b1;
    unique case (cond_code[3:1])
      3'b000:  w_base = w_z;
      3'b001:  w_base = w_c;
      3'b010:  w_base = w_n;
      3'b011:  w_base = w_v;
      3'b100:  w_base = w_c & ~w_z;
      3'b101:  w_base = (w_n == w_v);
      3'b110:  w_base = ~w_z & (w_n == w_v);
      default: w_base = 1'b1;
    endcase
  end

  // Odd codes invert their even partner, except 1111 (always).
  assign cond_true = (cond_code[0] && cond_code != 4'b1111)
                   ? ~w_base : w_base;

  assign mem_result     = r_lat.result;
  assign mem_store_data = r_lat.store_data;
  assign mem_rd         = r_lat.rd;
  assign mem_valid      = r_lat.valid;
  assign mem_regwrite   = r_lat.regwrite;
  assign mem_memread    = r_lat.memread;
  assign mem_memwrite   = r_lat.memwrite;
  assign mem_memtoreg   = r_lat.memtoreg;
  assign flags          = r_flags;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed scenarios plus a
// randomized run against a behavioural pipeline/flag model.
module tb_ex_mem_stage;

  localparam int DW = 64;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] ex_result;
  logic          ex_negative;
  logic          ex_zero;
  logic          ex_overflow;
  logic          ex_carry_out;
  logic          ex_valid;
  logic          ex_setflags;
  logic          ex_regwrite;
  logic          ex_memread;
  logic          ex_memwrite;
  logic          ex_memtoreg;
  logic [RW-1:0] ex_rd;
  logic [DW-1:0] ex_store_data;
  logic          stall;
  logic          flush;
  logic [3:0]    cond_code;
  logic [DW-1:0] mem_result;
  logic [DW-1:0] mem_store_data;
  logic [RW-1:0] mem_rd;
  logic          mem_valid;
  logic          mem_regwrite;
  logic          mem_memread;
  logic          mem_memwrite;
  logic          mem_memtoreg;
  logic [3:0]    flags;
  logic          cond_true;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex_mem_stage #(.DATA_W(DW), .REG_W(RW)) dut (
    .clk            (clk),
    .reset          (reset),
    .ex_result      (ex_result),
    .ex_negative    (ex_negative),
    .ex_zero        (ex_zero),
    .ex_overflow    (ex_overflow),
    .ex_carry_out   (ex_carry_out),
    .ex_valid       (ex_valid),
    .ex_setflags    (ex_setflags),
    .ex_regwrite    (ex_regwrite),
    .ex_memread     (ex_memread),
    .ex_memwrite    (ex_memwrite),
    .ex_memtoreg    (ex_memtoreg),
    .ex_rd          (ex_rd),
    .ex_store_data  (ex_store_data),
    .stall          (stall),
    .flush          (flush),
    .cond_code      (cond_code),
    .mem_result     (mem_result),
    .mem_store_data (mem_store_data),
    .mem_rd         (mem_rd),
    .mem_valid      (mem_valid),
    .mem_regwrite   (mem_regwrite),
    .mem_memread    (mem_memread),
    .mem_memwrite   (mem_memwrite),
    .mem_memtoreg   (mem_memtoreg),
    .flags          (flags),
    .cond_true      (cond_true)
  );

  // ARM condition table written straight from the encoding list.
  function automatic logic cond_ref(input logic [3:0] c,
                                    input logic [3:0] f);
    logic n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:    return z;
      4'd1:    return !z;
      4'd2:    return cy;
      4'd3:    return !cy;
      4'd4:    return n;
      4'd5:    return !n;
      4'd6:    return v;
      4'd7:    return !v;
      4'd8:    return cy && !z;
      4'd9:    return !cy || z;
      4'd10:   return n == v;
      4'd11:   return n != v;
      4'd12:   return !z && (n == v);
      4'd13:   return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  task automatic idle();
    reset = 0; flush = 0; stall = 0;
    ex_result = '0; ex_store_data = '0; ex_rd = '0;
    ex_negative = 0; ex_zero = 0;
    ex_overflow = 0; ex_carry_out = 0;
    ex_valid = 0; ex_setflags = 0;
    ex_regwrite = 0; ex_memread = 0;
    ex_memwrite = 0; ex_memtoreg = 0;
    cond_code = 4'b1110;
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle();
    reset = 1;
    @(posedge clk); #1;
    n_checks++;
    if ({mem_result, mem_store_data, mem_rd} !== '0) begin
      n_fail++;
      $display("FAIL reset_data got %h/%h/%h exp 0",
               mem_result, mem_store_data, mem_rd);
    end
    n_checks++;
    if ({mem_valid, mem_regwrite, mem_memread,
         mem_memwrite, mem_memtoreg} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got %b exp 00000",
               {mem_valid, mem_regwrite, mem_memread,
                mem_memwrite, mem_memtoreg});
    end
    n_checks++;
    if (flags !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags got %b exp 0000", flags);
    end
  endtask

  task automatic test_load();
    @(negedge clk);
    idle();
    ex_result = 64'h5; ex_rd = 5'd3;
    ex_regwrite = 1; ex_valid = 1;
    @(posedge clk); #1;
    n_checks++;
    if (mem_result !== 64'h5 || mem_rd !== 5'd3) begin
      n_fail++;
      $display("FAIL load_data got %h/%0d exp 5/3",
               mem_result, mem_rd);
    end
    n_checks++;
    if ({mem_valid, mem_regwrite, mem_memread} !== 3'b110) begin
      n_fail++;
      $display("FAIL load_ctrl got %b exp 110",
               {mem_valid, mem_regwrite, mem_memread});
    end
  endtask

  task automatic test_subs_bypass();
    @(negedge clk);
    idle();
    ex_valid = 1; ex_setflags = 1;
    ex_zero = 1; ex_carry_out = 1;
    cond_code = 4'b0000;
    #1;
    n_checks++;
    if (cond_true !== 1'b1) begin
      n_fail++;
      $display("FAIL subs_bypass got %b exp 1", cond_true);
    end
    @(posedge clk); #1;
    n_checks++;
    if (flags !== 4'b0110) begin
      n_fail++;
      $display("FAIL subs_flags got %b exp 0110", flags);
    end
    @(negedge clk);
    ex_valid = 0; ex_zero = 0; cond_code = 4'b0000;
    #1;
    n_checks++;
    if (cond_true !== 1'b1) begin
      n_fail++;
      $display("FAIL subs_stored_z got %b exp 1", cond_true);
    end
  endtask

  task automatic test_stall();
    @(negedge clk);
    idle();
    ex_result = 64'hAAAA; ex_rd = 5'd7;
    ex_valid = 1; ex_regwrite = 1;
    ex_setflags = 1; ex_negative = 1;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      stall = 1;
      ex_result = {$urandom, $urandom};
      ex_rd = RW'($urandom);
      ex_negative = 0; ex_zero = 1;
      ex_memread = 1;
      cond_code = 4'b0000;
      #1;
      n_checks++;
      if (cond_true !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_bypass[%0d] got %b exp 1",
                 i, cond_true);
      end
      @(posedge clk); #1;
      n_checks++;
      if (mem_result !== 64'hAAAA || mem_rd !== 5'd7 ||
          mem_memread !== 1'b0 || flags !== 4'b1000) begin
        n_fail++;
        $display("FAIL stall_hold[%0d] got %h/%0d/%b/%b exp aaaa/7/0/1000",
                 i, mem_result, mem_rd, mem_memread, flags);
      end
    end
    @(negedge clk);
    idle();
    ex_result = 64'hBBBB; ex_valid = 1;
    @(posedge clk); #1;
    n_checks++;
    if (mem_result !== 64'hBBBB || flags !== 4'b1000) begin
      n_fail++;
      $display("FAIL stall_release got %h/%b exp bbbb/1000",
               mem_result, flags);
    end
  endtask

  task automatic test_flush_stall();
    @(negedge clk);
    idle();
    ex_valid = 1; ex_setflags = 1;
    @(posedge clk);
    @(negedge clk);
    flush = 1; stall = 1;
    ex_valid = 1; ex_setflags = 1; ex_negative = 1;
    ex_regwrite = 1; ex_memwrite = 1; ex_result = 64'h1234;
    cond_code = 4'b0100;
    #1;
    n_checks++;
    if (cond_true !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_cond got %b exp 0", cond_true);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({mem_valid, mem_regwrite, mem_memread,
         mem_memwrite, mem_memtoreg} !== 5'b0 ||
        mem_result !== '0) begin
      n_fail++;
      $display("FAIL flush_ctrl got %b/%h exp 00000/0",
               {mem_valid, mem_regwrite, mem_memread,
                mem_memwrite, mem_memtoreg}, mem_result);
    end
    n_checks++;
    if (flags !== 4'b0000) begin
      n_fail++;
      $display("FAIL flush_flags got %b exp 0000", flags);
    end
  endtask

  task automatic test_invalid();
    @(negedge clk);
    idle();
    ex_valid = 0; ex_memwrite = 1; ex_setflags = 1;
    ex_negative = 1; ex_zero = 1; ex_result = 64'h77;
    cond_code = 4'b0000;
    #1;
    n_checks++;
    if (cond_true !== 1'b0) begin
      n_fail++;
      $display("FAIL invalid_cond got %b exp 0", cond_true);
    end
    @(posedge clk); #1;
    n_checks++;
    if (mem_memwrite !== 1'b0 || mem_valid !== 1'b0 ||
        flags !== 4'b0000 || mem_result !== 64'h77) begin
      n_fail++;
      $display("FAIL invalid_load got %b/%b/%b/%h exp 0/0/0000/77",
               mem_memwrite, mem_valid, flags, mem_result);
    end
  endtask

  task automatic test_reset_in_stall();
    @(negedge clk);
    idle();
    ex_valid = 1; ex_setflags = 1; ex_regwrite = 1;
    ex_negative = 1; ex_carry_out = 1; ex_overflow = 1;
    ex_result = 64'hDEAD; ex_rd = 5'd9;
    @(posedge clk);
    @(negedge clk);
    reset = 1; stall = 1;
    ex_zero = 1; cond_code = 4'b0000;
    #1;
    n_checks++;
    if (cond_true !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_no_bypass got %b exp 0", cond_true);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({mem_result, mem_rd, mem_valid, mem_regwrite} !== '0 ||
        flags !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_stall got %h/%0d/%b/%b flags %b exp zeros",
               mem_result, mem_rd, mem_valid, mem_regwrite, flags);
    end
    @(negedge clk);
    cond_code = 4'b1110;
    #1;
    n_checks++;
    if (cond_true !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_al got %b exp 1", cond_true);
    end
    cond_code = 4'b0000;
    #1;
    n_checks++;
    if (cond_true !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_eq got %b exp 0", cond_true);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] m_res, m_st;
    logic [RW-1:0] m_rd;
    logic [4:0]    m_ctl;
    logic [3:0]    m_flags, live, eff;
    logic          exp_c;
    @(negedge clk);
    idle();
    reset = 1;
    @(posedge clk);
    m_res = '0; m_st = '0; m_rd = '0;
    m_ctl = '0; m_flags = '0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      reset         = ($urandom_range(0, 31) == 0);
      flush         = ($urandom_range(0, 7) == 0);
      stall         = ($urandom_range(0, 4) == 0);
      ex_valid      = ($urandom_range(0, 3) != 0);
      ex_setflags   = 1'($urandom);
      ex_negative   = 1'($urandom);
      ex_zero       = 1'($urandom);
      ex_carry_out  = 1'($urandom);
      ex_overflow   = 1'($urandom);
      ex_regwrite   = 1'($urandom);
      ex_memread    = 1'($urandom);
      ex_memwrite   = 1'($urandom);
      ex_memtoreg   = 1'($urandom);
      ex_rd         = RW'($urandom);
      ex_result     = {$urandom, $urandom};
      ex_store_data = {$urandom, $urandom};
      cond_code     = 4'($urandom);
      live = {ex_negative, ex_zero, ex_carry_out, ex_overflow};
      eff  = (ex_valid && ex_setflags && !flush && !reset)
           ? live : m_flags;
      exp_c = cond_ref(cond_code, eff);
      #1;
      n_checks++;
      if (cond_true !== exp_c) begin
        n_fail++;
        $display("FAIL rand_cond[%0d] code %b got %b exp %b",
                 i, cond_code, cond_true, exp_c);
      end
      @(posedge clk);
      if (reset) begin
        m_res = '0; m_st = '0; m_rd = '0;
        m_ctl = '0; m_flags = '0;
      end else if (flush) begin
        m_res = '0; m_st = '0; m_rd = '0; m_ctl = '0;
      end else if (!stall) begin
        m_res = ex_result; m_st = ex_store_data; m_rd = ex_rd;
        m_ctl = ex_valid ? {1'b1, ex_regwrite, ex_memread,
                            ex_memwrite, ex_memtoreg} : 5'b0;
        if (ex_valid && ex_setflags) m_flags = live;
      end
      #1;
      n_checks++;
      if ({mem_result, mem_store_data, mem_rd} !==
          {m_res, m_st, m_rd}) begin
        n_fail++;
        $display("FAIL rand_data[%0d] got %h/%h/%0d exp %h/%h/%0d",
                 i, mem_result, mem_store_data, mem_rd,
                 m_res, m_st, m_rd);
      end
      n_checks++;
      if ({mem_valid, mem_regwrite, mem_memread,
           mem_memwrite, mem_memtoreg, flags} !==
          {m_ctl, m_flags}) begin
        n_fail++;
        $display("FAIL rand_ctl[%0d] got %b/%b exp %b/%b",
                 i, {mem_valid, mem_regwrite, mem_memread,
                     mem_memwrite, mem_memtoreg}, flags,
                 m_ctl, m_flags);
      end
    end
  endtask

  initial begin
    idle();
    reset = 1;
    test_reset();
    test_load();
    test_subs_bypass();
    test_stall();
    test_flush_stall();
    test_invalid();
    test_reset_in_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
